// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core-favoured sharing with an auxiliary requester,
// starvation-bounded auxiliary access, and read-response routing to the issuer.
package dmem_pkg;
    typedef enum logic [1:0] {
        MEM_DISABLED = 2'd0,
        MEM_READ     = 2'd1,
        MEM_WRITE    = 2'd2
    } memaccess_t;
endpackage

module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  memaccess_t       core_memaccess,
    input  logic [29:0]      core_word_addr,
    input  logic [3:0]       core_wstrb,
    input  logic [31:0]      core_wdata,
    output logic             core_stall,
    output logic             core_rvalid,
    output logic [31:0]      core_rdata,
    output logic             core_fault,
    input  logic             aux_req,
    input  logic             aux_write,
    input  logic [29:0]      aux_word_addr,
    input  logic [3:0]       aux_wstrb,
    input  logic [31:0]      aux_wdata,
    output logic             aux_gnt,
    output logic             aux_rvalid,
    output logic [31:0]      aux_rdata,
    output logic             aux_fault,
    output memaccess_t       mem_memaccess,
    output logic [29:0]      mem_word_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_fault
);

    typedef enum logic {CORE_PRI, AUX_PRI} pri_e;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    pri_e        pri_q, pri_d;
    logic [3:0]  wait_q, wait_d;
    logic        rsp_v_q, rsp_v_d;
    logic        rsp_own_q, rsp_own_d;   // 1 = auxiliary owns the pending read
    logic        core_act;
    logic        core_gnt;
    memaccess_t  aux_ma;

    always_comb begin
        core_act = core_memaccess != MEM_DISABLED;
        aux_ma   = aux_write ? MEM_WRITE : MEM_READ;
        core_gnt = 1'b0;
        aux_gnt  = 1'b0;
        if (!rst) begin
            if (pri_q == AUX_PRI && aux_req) aux_gnt  = 1'b1;
            else if (core_act)               core_gnt = 1'b1;
            else if (aux_req)                aux_gnt  = 1'b1;
        end
        core_stall = !rst && core_act && !core_gnt;

        mem_memaccess = MEM_DISABLED;
        mem_word_addr = '0;
        mem_wstrb     = '0;
        mem_wdata     = '0;
        if (aux_gnt) begin
            mem_memaccess = aux_ma;
            mem_word_addr = aux_word_addr;
            mem_wstrb     = aux_wstrb;
            mem_wdata     = aux_wdata;
        end else if (core_gnt) begin
            mem_memaccess = core_memaccess;
            mem_word_addr = core_word_addr;
            mem_wstrb     = core_wstrb;
            mem_wdata     = core_wdata;
        end

        core_fault = core_gnt && mem_fault;
        aux_fault  = aux_gnt && mem_fault;

        // AUX_PRI lasts exactly one cycle: either aux is granted or it has gone away.
        pri_d  = pri_q;
        wait_d = wait_q;
        if (pri_q == AUX_PRI) begin
            pri_d  = CORE_PRI;
            wait_d = '0;
        end else if (aux_gnt) begin
            wait_d = '0;
        end else if (aux_req && wait_q != MAX_W) begin
            wait_d = 4'(wait_q + 4'd1);
            if (wait_d == MAX_W) pri_d = AUX_PRI;
        end

        rsp_v_d   = mem_memaccess == MEM_READ;
        rsp_own_d = aux_gnt;

        core_rvalid = !rst && rsp_v_q && !rsp_own_q;
        aux_rvalid  = !rst && rsp_v_q && rsp_own_q;
        core_rdata  = mem_rdata;
        aux_rdata   = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q     <= CORE_PRI;
            wait_q    <= '0;
            rsp_v_q   <= 1'b0;
            rsp_own_q <= 1'b0;
        end else begin
            pri_q     <= pri_d;
            wait_q    <= wait_d;
            rsp_v_q   <= rsp_v_d;
            rsp_own_q <= rsp_own_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed vector table plus randomized traffic checked against a starvation-count model.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    memaccess_t  core_memaccess;
    logic [29:0] core_word_addr;
    logic [3:0]  core_wstrb;
    logic [31:0] core_wdata;
    logic        core_stall, core_rvalid, core_fault;
    logic [31:0] core_rdata;
    logic        aux_req, aux_write;
    logic [29:0] aux_word_addr;
    logic [3:0]  aux_wstrb;
    logic [31:0] aux_wdata;
    logic        aux_gnt, aux_rvalid, aux_fault;
    logic [31:0] aux_rdata;
    memaccess_t  mem_memaccess;
    logic [29:0] mem_word_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_fault;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .core_memaccess(core_memaccess), .core_word_addr(core_word_addr),
        .core_wstrb(core_wstrb), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_fault(core_fault),
        .aux_req(aux_req), .aux_write(aux_write), .aux_word_addr(aux_word_addr),
        .aux_wstrb(aux_wstrb), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
        .aux_rdata(aux_rdata), .aux_fault(aux_fault),
        .mem_memaccess(mem_memaccess), .mem_word_addr(mem_word_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_fault(mem_fault)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        logic rst; memaccess_t cma; logic [29:0] caddr; logic [3:0] cws;
        logic areq, awr; logic [29:0] aaddr; logic [3:0] aws;
        logic [31:0] mrd; logic mf;
        logic e_stall, e_agnt; memaccess_t e_mma; logic [29:0] e_maddr; logic [3:0] e_mws;
        logic e_crv, e_arv, e_cf, e_af;
    } vec_t;

    function automatic vec_t v(
        logic r, memaccess_t cma, logic [29:0] caddr, logic [3:0] cws,
        logic areq, logic awr, logic [29:0] aaddr, logic [3:0] aws,
        logic [31:0] mrd, logic mf,
        logic es, logic eg, memaccess_t emma, logic [29:0] emaddr, logic [3:0] emws,
        logic ecrv, logic earv, logic ecf, logic eaf);
        vec_t t;
        t.rst = r; t.cma = cma; t.caddr = caddr; t.cws = cws;
        t.areq = areq; t.awr = awr; t.aaddr = aaddr; t.aws = aws;
        t.mrd = mrd; t.mf = mf;
        t.e_stall = es; t.e_agnt = eg; t.e_mma = emma; t.e_maddr = emaddr; t.e_mws = emws;
        t.e_crv = ecrv; t.e_arv = earv; t.e_cf = ecf; t.e_af = eaf;
        return t;
    endfunction

    function automatic logic [31:0] cwd(logic [29:0] a); return 32'hC000_0000 | {2'b00, a}; endfunction
    function automatic logic [31:0] awd(logic [29:0] a); return 32'hA000_0000 | {2'b00, a}; endfunction

    task automatic drive(input logic r, input memaccess_t cma, input logic [29:0] caddr,
                         input logic [3:0] cws, input logic [31:0] cwdat,
                         input logic areq, input logic awr, input logic [29:0] aaddr,
                         input logic [3:0] aws, input logic [31:0] awdat,
                         input logic [31:0] mrd, input logic mf);
        rst = r; core_memaccess = cma; core_word_addr = caddr; core_wstrb = cws;
        core_wdata = cwdat; aux_req = areq; aux_write = awr; aux_word_addr = aaddr;
        aux_wstrb = aws; aux_wdata = awdat; mem_rdata = mrd; mem_fault = mf;
    endtask

    vec_t tbl[$];

    // Random-phase reference model: count of consecutive denied aux cycles
    int          starve;
    bit          prv_rd, prv_aux;

    initial begin
        vec_t t;
        logic [31:0] e_wd;
        drive(1, MEM_DISABLED, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset gating
        tbl.push_back(v(1, MEM_READ, 'h10, 0, 1, 0, 'h30, 0, 0, 0,  0, 0, MEM_DISABLED, 0, 0, 0, 0, 0, 0));
        // core-only read, response next cycle
        tbl.push_back(v(0, MEM_READ, 'h10, 0, 0, 0, 0, 0, 0, 0,  0, 0, MEM_READ, 'h10, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 0, 0, 0, 0, 'hDEADBEEF, 0,  0, 0, MEM_DISABLED, 0, 0, 1, 0, 0, 0));
        // aux-only write, no response
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 1, 1, 'h20, 4'b0011, 0, 0,  0, 1, MEM_WRITE, 'h20, 4'b0011, 0, 0, 0, 0));
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 0, 0, 0, 0, 'h11111111, 0,  0, 0, MEM_DISABLED, 0, 0, 0, 0, 0, 0));
        // starvation: aux forced through on the 5th cycle
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h20000005, 0,  0, 0, MEM_READ, 'h100, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h20000006, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h20000007, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h20000008, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h20000009, 0,  1, 1, MEM_READ, 'h30, 0, 1, 0, 0, 0));
        // core granted again; aux response; then alternating owners
        tbl.push_back(v(0, MEM_READ, 'h11, 0, 0, 0, 0, 0, 'hAAAA0010, 0,  0, 0, MEM_READ, 'h11, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 1, 0, 'h40, 0, 'hC0DE0011, 0,  0, 1, MEM_READ, 'h40, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 0, 0, 0, 0, 'hA0DE0012, 0,  0, 0, MEM_DISABLED, 0, 0, 0, 1, 0, 0));
        // fault goes only to the granted core
        tbl.push_back(v(0, MEM_WRITE, 'h50, 4'hF, 1, 0, 'h60, 0, 0, 1,  0, 0, MEM_WRITE, 'h50, 4'hF, 0, 0, 1, 0));
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 1, 0, 'h60, 0, 0, 0,  0, 1, MEM_READ, 'h60, 0, 0, 0, 0, 0));
        // reset right after a granted aux read drops the response
        tbl.push_back(v(1, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h15151515, 0,  0, 0, MEM_DISABLED, 0, 0, 0, 0, 0, 0));
        // partial starvation then reset: wait count must restart from zero
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h16, 0,  0, 0, MEM_READ, 'h100, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h17, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h18, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h19, 0,  0, 0, MEM_DISABLED, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h20, 0,  0, 0, MEM_READ, 'h100, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h21, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h22, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h23, 0,  0, 0, MEM_READ, 'h100, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_READ, 'h100, 0, 1, 0, 'h30, 0, 'h24, 0,  1, 1, MEM_READ, 'h30, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, MEM_DISABLED, 0, 0, 0, 0, 0, 0, 'h25, 0,  0, 0, MEM_DISABLED, 0, 0, 0, 1, 0, 0));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            drive(t.rst, t.cma, t.caddr, t.cws, cwd(t.caddr), t.areq, t.awr, t.aaddr, t.aws,
                  awd(t.aaddr), t.mrd, t.mf);
            @(negedge clk);
            e_wd = (t.e_mma == MEM_DISABLED) ? 32'h0 : (t.e_agnt ? awd(t.e_maddr) : cwd(t.e_maddr));
            chk($sformatf("v%0d core_stall", i), 64'(core_stall), 64'(t.e_stall));
            chk($sformatf("v%0d aux_gnt", i), 64'(aux_gnt), 64'(t.e_agnt));
            chk($sformatf("v%0d mem_memaccess", i), 64'(mem_memaccess), 64'(t.e_mma));
            chk($sformatf("v%0d mem_word_addr", i), 64'(mem_word_addr), 64'(t.e_maddr));
            chk($sformatf("v%0d mem_wstrb", i), 64'(mem_wstrb), 64'(t.e_mws));
            chk($sformatf("v%0d mem_wdata", i), 64'(mem_wdata), 64'(e_wd));
            chk($sformatf("v%0d core_rvalid", i), 64'(core_rvalid), 64'(t.e_crv));
            chk($sformatf("v%0d aux_rvalid", i), 64'(aux_rvalid), 64'(t.e_arv));
            chk($sformatf("v%0d core_fault", i), 64'(core_fault), 64'(t.e_cf));
            chk($sformatf("v%0d aux_fault", i), 64'(aux_fault), 64'(t.e_af));
            if (t.e_crv) chk($sformatf("v%0d core_rdata", i), 64'(core_rdata), 64'(t.mrd));
            if (t.e_arv) chk($sformatf("v%0d aux_rdata", i), 64'(aux_rdata), 64'(t.mrd));
            @(posedge clk); #1;
        end

        // Randomized traffic; aux payload held until granted
        begin
            bit          apend = 0;
            bit          awr_r = 0;
            logic [29:0] aaddr_r = '0;
            logic [3:0]  aws_r = '0;
            logic [31:0] awd_r = '0;
            bit          r_rst, c_act, forced, a_win, c_win, e_rd;
            memaccess_t  cma, e_mma;
            logic [29:0] caddr, e_addr;
            logic [3:0]  cws, e_ws;
            logic [31:0] cwdat, mrd, e_wd2;
            logic        mf;
            starve = 0; prv_rd = 0; prv_aux = 0;
            for (int c = 0; c < 600; c++) begin
                r_rst = (c == 0) || ($urandom_range(0, 39) == 0);
                case ($urandom_range(0, 3))
                    0:       cma = MEM_DISABLED;
                    3:       cma = MEM_WRITE;
                    default: cma = MEM_READ;
                endcase
                caddr = 30'($urandom); cws = 4'($urandom); cwdat = $urandom;
                if (!apend && $urandom_range(0, 2) == 0) begin
                    apend = 1; awr_r = 1'($urandom); aaddr_r = 30'($urandom);
                    aws_r = 4'($urandom); awd_r = $urandom;
                end
                mrd = $urandom; mf = ($urandom_range(0, 3) == 0);
                drive(r_rst, cma, caddr, cws, cwdat, apend, awr_r, aaddr_r, aws_r, awd_r, mrd, mf);

                c_act  = cma != MEM_DISABLED;
                forced = starve >= MAXW;
                a_win  = !r_rst && apend && (!c_act || forced);
                c_win  = !r_rst && c_act && !a_win;
                e_mma = MEM_DISABLED; e_addr = '0; e_ws = '0; e_wd2 = '0;
                if (a_win) begin
                    e_mma = awr_r ? MEM_WRITE : MEM_READ;
                    e_addr = aaddr_r; e_ws = aws_r; e_wd2 = awd_r;
                end else if (c_win) begin
                    e_mma = cma; e_addr = caddr; e_ws = cws; e_wd2 = cwdat;
                end
                e_rd = e_mma == MEM_READ;

                @(negedge clk);
                chk($sformatf("r%0d core_stall", c), 64'(core_stall), 64'(!r_rst && c_act && !c_win));
                chk($sformatf("r%0d aux_gnt", c), 64'(aux_gnt), 64'(a_win));
                chk($sformatf("r%0d mem_memaccess", c), 64'(mem_memaccess), 64'(e_mma));
                chk($sformatf("r%0d mem_word_addr", c), 64'(mem_word_addr), 64'(e_addr));
                chk($sformatf("r%0d mem_wstrb", c), 64'(mem_wstrb), 64'(e_ws));
                chk($sformatf("r%0d mem_wdata", c), 64'(mem_wdata), 64'(e_wd2));
                chk($sformatf("r%0d core_fault", c), 64'(core_fault), 64'(c_win && mf));
                chk($sformatf("r%0d aux_fault", c), 64'(aux_fault), 64'(a_win && mf));
                chk($sformatf("r%0d core_rvalid", c), 64'(core_rvalid), 64'(!r_rst && prv_rd && !prv_aux));
                chk($sformatf("r%0d aux_rvalid", c), 64'(aux_rvalid), 64'(!r_rst && prv_rd && prv_aux));
                if (!r_rst && prv_rd && !prv_aux) chk($sformatf("r%0d core_rdata", c), 64'(core_rdata), 64'(mrd));
                if (!r_rst && prv_rd && prv_aux)  chk($sformatf("r%0d aux_rdata", c), 64'(aux_rdata), 64'(mrd));

                if (r_rst) begin
                    starve = 0; prv_rd = 0; prv_aux = 0;
                end else begin
                    if (a_win || forced) starve = 0;
                    else if (apend)      starve = (starve + 1 > MAXW) ? MAXW : starve + 1;
                    prv_rd = e_rd; prv_aux = a_win;
                end
                if (a_win) apend = 0;
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the core load/store path and an auxiliary requester (program loader / debug access). The core is favoured, but a starvation counter guarantees the auxiliary port forward progress. The block also routes the one-cycle-delayed read response back to the requester that issued the read. It sits between the MEM1 stage's store-align output and `data_memory`, and drives a stall request into the hazard unit.

## Interface
- `MAX_WAIT`, default 4: number of consecutive denied auxiliary cycles after which the auxiliary port is forced through. Legal range is 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `core_memaccess`  in  `memaccess_t`: core request; `MEM_DISABLED` means idle.
- `core_word_addr`  in  30; `core_wstrb`  in  4; `core_wdata`  in  32: core address and aligned store data.
- `core_stall`  out  1: core request is active but not granted this cycle; the hazard unit holds MEM1.
- `core_rvalid`  out  1; `core_rdata`  out  32: core read response.
- `core_fault`  out  1: access fault for the core's granted access, same cycle as the grant.
- `aux_req`  in  1; `aux_write`  in  1; `aux_word_addr`  in  30; `aux_wstrb`  in  4; `aux_wdata`  in  32: auxiliary request.
- `aux_gnt`  out  1: auxiliary request accepted this cycle.
- `aux_rvalid`  out  1; `aux_rdata`  out  32; `aux_fault`  out  1: auxiliary response and fault.
- `mem_memaccess`  out  `memaccess_t`; `mem_word_addr`  out  30; `mem_wstrb`  out  4; `mem_wdata`  out  32: memory request.
- `mem_rdata`  in  32: registered read data, valid 1 cycle after the read.
- `mem_fault`  in  1: combinational fault for the current-cycle access.

## Operation
- Definitions:
  - `core_act = core_memaccess != MEM_DISABLED`.
  - The auxiliary access type is `MEM_WRITE` if `aux_write`, otherwise `MEM_READ`.
- State machine `pri_q` has two states:
  - `CORE_PRI` (reset state):
    - If `core_act`, the core is granted.
    - Otherwise, if `aux_req`, the auxiliary port is granted.
  - `AUX_PRI`:
    - If `aux_req`, the auxiliary port is granted. If `core_act` is also high, `core_stall` = 1.
    - If `aux_req` is low, the core is granted as in `CORE_PRI`.
- Wait counter `wait_q` (4 bits):
  - Cleared on reset and on any `aux_gnt`.
  - Incremented when `aux_req && !aux_gnt`.
  - Saturates at `MAX_WAIT`.
- State transitions:
  - `CORE_PRI` → `AUX_PRI` when `wait_q` reaches `MAX_WAIT`, i.e. on the increment that makes it equal.
  - `AUX_PRI` → `CORE_PRI` after one `aux_gnt`, or if `aux_req` is low.
  - On either exit from `AUX_PRI`, `wait_q` is cleared.
- Request mux:
  - The granted requester's memaccess, address, wstrb and wdata drive the `mem_*` outputs.
  - With no grant: `mem_memaccess = MEM_DISABLED`, and all other `mem_*` outputs are 0.
- Fault routing:
  - `mem_fault` is ANDed with the grant and presented on `core_fault` or `aux_fault` in the same cycle.
  - A non-granted requester always sees fault = 0.
- Response tracking:
  - Registers `rsp_v_q` and `rsp_own_q` are set on every cycle with a granted `MEM_READ`.
  - `rsp_v_q` is cleared when there is no read.
  - Next cycle: `core_rvalid = rsp_v_q && rsp_own_q == CORE`, and likewise for aux.
  - Both `*_rdata = mem_rdata`, and are qualified only by their respective `rvalid`.
- Writes produce no response.
- Back-to-back reads by alternating owners are supported, since each response is owned by the previous cycle's grant.

## Timing
- Grant, `core_stall` and `mem_*` are combinational from the requests and `pri_q`; there is zero-cycle arbitration latency.
- Read data returns exactly 1 cycle after the grant. Faults are reported in the grant cycle.
- Worst-case auxiliary latency is `MAX_WAIT`+1 cycles from `aux_req` rise to `aux_gnt`, under continuous core traffic.
- The core stalls at most 1 cycle per `MAX_WAIT`+1 cycles of contention.
- `aux_req` and its payload must be held stable until `aux_gnt`. The core holds MEM1 while stalled.
- Reset values, registered on the `rst` edge:
  - `pri_q = CORE_PRI`, `wait_q = 0`, `rsp_v_q = 0`.
  - While `rst` is high: all grants = 0, `core_stall = 0`, `mem_memaccess = MEM_DISABLED`, both `rvalid = 0`, both faults = 0.
- Reset mid-read: the pending response is dropped, and neither `rvalid` asserts in the following cycle.
- Simultaneous request in `CORE_PRI`: the core wins and `wait_q` increments.
- Simultaneous request in `AUX_PRI`: the auxiliary port wins and `core_stall` = 1.

## Test plan
- Core-only traffic: core read at 0x10 with `mem_rdata` = 0xDEADBEEF → `core_stall` = 0, and `core_rvalid` = 1 with 0xDEADBEEF the next cycle; `aux_rvalid` stays 0.
- Aux-only traffic: aux write to `word_addr` 0x20, `wstrb` 4'b0011 → `aux_gnt` = 1 in the same cycle; `mem_memaccess = MEM_WRITE` with addr/strobe passed through; no `rvalid`.
- Starvation with `MAX_WAIT` = 4: continuous core reads plus held `aux_req` → `aux_gnt` on the 5th cycle, `core_stall` = 1 only in that cycle, and core granted again the cycle after.
- Alternating reads: core read in cycle N, aux read in cycle N+1 → `core_rvalid` in N+1 and `aux_rvalid` in N+2, each with its own `mem_rdata`.
- Fault routing: `mem_fault` = 1 on a granted core write while aux is waiting → `core_fault` = 1 and `aux_fault` = 0 in the same cycle.
- Reset: `rst` asserted in the cycle after a granted aux read → `aux_rvalid` = 0, `pri_q` back to `CORE_PRI`, and `wait_q` = 0.
